// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg: constants, types and the MISO bit-select helper shared by SPI blocks
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

    localparam logic       SPI_CLOCK_IDLE = 1'b1;
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] SPI_FILL_BYTE  = 8'hFF;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } slave_state_e;

    typedef logic [31:0] spi_word_t;
    typedef logic [2:0]  spi_bcnt_t;

    // Bytes at or beyond the word's valid count go out as the fill byte.
    function automatic logic tx_bit(input spi_word_t w, input spi_bcnt_t nvalid,
                                    input logic [1:0] byte_idx, input logic [2:0] bit_idx);
        if ({1'b0, byte_idx} >= nvalid) begin
            return SPI_FILL_BYTE[bit_idx];
        end
        return w[{byte_idx, bit_idx}];
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_slave_control_if.sv
// ----------------------------------------------------------------------------
// spi_slave_control_if: word-side tx holding / rx valid-ack handshake bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface spi_slave_control_if;
    import spi_pkg::*;

    spi_word_t tx_data_i;
    spi_bcnt_t tx_bytes_valid_i;
    logic      tx_load_i;
    logic      tx_ready_o;
    spi_word_t rx_data_o;
    spi_bcnt_t rx_bytes_valid_o;
    logic      rx_valid_o;
    logic      rx_ack_i;
    logic      rx_overrun_o;

    modport slave (
        input  tx_data_i, tx_bytes_valid_i, tx_load_i, rx_ack_i,
        output tx_ready_o, rx_data_o, rx_bytes_valid_o, rx_valid_o, rx_overrun_o
    );

    modport master (
        output tx_data_i, tx_bytes_valid_i, tx_load_i, rx_ack_i,
        input  tx_ready_o, rx_data_o, rx_bytes_valid_o, rx_valid_o, rx_overrun_o
    );

endinterface

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ----------------------------------------------------------------------------
// spi_sync_edge: SYNC_STAGES-deep synchroniser with rise/fall pulses (SYNC_STAGES >= 2)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic d_i,
    output logic      rise_o,
    output logic      fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave_control.sv
// ----------------------------------------------------------------------------
// spi_slave_control: oversampled SPI responder packing rx bytes into words and
// serialising a one-deep tx holding register.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_slave_control
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    input  wire logic          spi_clk_i,
    input  wire logic          spi_cs_n_i,
    input  wire logic          spi_mosi_i,
    output logic               spi_miso_o,
    output logic               frame_err_o,
    output logic               busy_o,
    spi_slave_control_if.slave bus
);

    logic clk_rise_w, clk_fall_w, cs_rise_w, cs_fall_w, mosi_w;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_CLOCK_IDLE)) u_clk_sync (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_clk_i), .rise_o(clk_rise_w), .fall_o(clk_fall_w)
    );

    // Reset to the asserted level so a cs_n held low across reset never looks like a new frame.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_cs_n_i), .rise_o(cs_rise_w), .fall_o(cs_fall_w)
    );

    assign mosi_w = mosi_sync_q[SYNC_STAGES-1];

    slave_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [1:0]   byte_cnt_q, byte_cnt_d;
    spi_bcnt_t    fill_q, fill_d;
    logic [7:0]   rx_byte_q, rx_byte_d;
    spi_word_t    word_q, word_d, shift_q, shift_d, hold_q, hold_d;
    spi_bcnt_t    shift_nv_q, shift_nv_d, hold_nv_q, hold_nv_d;
    logic         hold_full_q, hold_full_d, miso_q, miso_d, frame_err_q, frame_err_d;
    spi_word_t    rx_data_q, rx_data_d, reload_word_w, pub_data_w;
    spi_bcnt_t    rx_bv_q, rx_bv_d, reload_nv_w, pub_bv_w;
    logic         rx_valid_q, rx_valid_d, overrun_q, overrun_d, reload_w, publish_w;

    assign reload_word_w = hold_full_q ? hold_q : '1;
    assign reload_nv_w   = hold_full_q ? hold_nv_q : 3'd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mosi_sync_q <= '1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            fill_q      <= '0;
            rx_byte_q   <= '0;
            word_q      <= '0;
            shift_q     <= '1;
            shift_nv_q  <= '0;
            hold_q      <= '0;
            hold_nv_q   <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b1;
            frame_err_q <= 1'b0;
            rx_data_q   <= '0;
            rx_bv_q     <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            fill_q      <= fill_d;
            rx_byte_q   <= rx_byte_d;
            word_q      <= word_d;
            shift_q     <= shift_d;
            shift_nv_q  <= shift_nv_d;
            hold_q      <= hold_d;
            hold_nv_q   <= hold_nv_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
            rx_bv_q     <= rx_bv_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        fill_d      = fill_q;
        rx_byte_d   = rx_byte_q;
        word_d      = word_q;
        miso_d      = miso_q;
        frame_err_d = 1'b0;
        reload_w    = 1'b0;
        publish_w   = 1'b0;
        pub_data_w  = word_q;
        pub_bv_w    = fill_q;

        case (state_q)
            IDLE: begin
                miso_d = 1'b1;
                if (cs_fall_w) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    fill_d     = '0;
                    word_d     = '0;
                    reload_w   = 1'b1;
                    miso_d     = tx_bit(reload_word_w, reload_nv_w, 2'd0, 3'd0);
                end
            end
            ACTIVE: begin
                if (cs_rise_w) begin
                    state_d     = IDLE;
                    miso_d      = 1'b1;
                    publish_w   = (fill_q != 3'd0);
                    frame_err_d = (bit_cnt_q != 3'd0);
                end else if (clk_rise_w) begin
                    // bit_cnt counts sampled bits; the falling edge drives the bit it points at.
                    rx_byte_d[bit_cnt_q] = mosi_w;
                    bit_cnt_d            = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        word_d[{fill_q[1:0], 3'b000} +: 8] = rx_byte_d;
                        fill_d     = fill_q + 3'd1;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        reload_w   = (byte_cnt_q == 2'd3);
                        if (fill_d == 3'(BYTES_PER_WORD)) begin
                            publish_w  = 1'b1;
                            pub_data_w = word_d;
                            pub_bv_w   = fill_d;
                            fill_d     = '0;
                            word_d     = '0;
                        end
                    end
                end else if (clk_fall_w) begin
                    miso_d = tx_bit(shift_q, shift_nv_q, byte_cnt_q, bit_cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase

        shift_d     = shift_q;
        shift_nv_d  = shift_nv_q;
        hold_d      = hold_q;
        hold_nv_d   = hold_nv_q;
        hold_full_d = hold_full_q;
        if (reload_w) begin
            shift_d     = reload_word_w;
            shift_nv_d  = reload_nv_w;
            hold_full_d = 1'b0;
        end
        if (bus.tx_load_i && !hold_full_q) begin
            hold_d      = bus.tx_data_i;
            hold_nv_d   = bus.tx_bytes_valid_i;
            hold_full_d = 1'b1;
        end

        rx_data_d  = rx_data_q;
        rx_bv_d    = rx_bv_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (publish_w) begin
            rx_data_d  = pub_data_w;
            rx_bv_d    = pub_bv_w;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !bus.rx_ack_i) begin
                overrun_d = 1'b1;
            end
        end else if (bus.rx_ack_i) begin
            rx_valid_d = 1'b0;
        end
    end

    assign spi_miso_o           = miso_q;
    assign frame_err_o          = frame_err_q;
    assign busy_o               = (state_q == ACTIVE);
    assign bus.tx_ready_o       = ~hold_full_q;
    assign bus.rx_data_o        = rx_data_q;
    assign bus.rx_bytes_valid_o = rx_bv_q;
    assign bus.rx_valid_o       = rx_valid_q;
    assign bus.rx_overrun_o     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_control.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_control: SPI master model driving randomised frames into the responder
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_slave_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_clk = 1'b1;
    logic cs_n = 1'b1;
    logic mosi = 1'b1;
    logic miso, frame_err, busy;

    spi_slave_control_if bus();

    spi_slave_control #(.SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .spi_clk_i(spi_clk), .spi_cs_n_i(cs_n),
        .spi_mosi_i(mosi), .spi_miso_o(miso), .frame_err_o(frame_err),
        .busy_o(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int fe_cnt  = 0;
    logic [127:0] miso_cap;

    always @(posedge clk) if (frame_err) fe_cnt <= fe_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_tx_byte(input logic [31:0] w, input int nv, input int idx);
        logic [7:0] b;
        b = w[8*idx +: 8];
        return (idx >= nv) ? 8'hFF : b;
    endfunction

    task automatic frame_begin();
        @(negedge clk) cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_bits(input int nbits, input logic [127:0] bits);
        for (int i = 0; i < nbits; i++) begin
            spi_clk = 1'b0;
            mosi    = bits[i];
            repeat (5) @(negedge clk);
            miso_cap[i] = miso;
            spi_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        mosi = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic ack_rx();
        @(negedge clk) bus.rx_ack_i = 1'b1;
        @(negedge clk) bus.rx_ack_i = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        logic [40:0] got, exp;
        got = {miso, bus.tx_ready_o, bus.rx_data_o, bus.rx_bytes_valid_o,
               bus.rx_valid_o, bus.rx_overrun_o, frame_err, busy};
        exp = {1'b1, 1'b1, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
    endtask

    task automatic test_full_word();
        for (int k = 0; k < 4; k++) begin
            logic [31:0]  w;
            logic [127:0] bits;
            int           fe0;
            w    = (k == 0) ? 32'h44332211 : $urandom;
            bits = '0;
            bits[31:0] = w;
            fe0  = fe_cnt;
            frame_begin();
            frame_bits(32, bits);
            frame_end();
            n_tests++;
            if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== w || bus.rx_bytes_valid_o !== 3'd4) begin
                n_fail++;
                $display("FAIL full_word[%0d]: valid=%b data=%h bv=%0d expected valid=1 data=%h bv=4",
                         k, bus.rx_valid_o, bus.rx_data_o, bus.rx_bytes_valid_o, w);
            end
            n_tests++;
            if (fe_cnt !== fe0 || miso_cap[31:0] !== 32'hFFFFFFFF) begin
                n_fail++;
                $display("FAIL full_word_aux[%0d]: frame_err pulses=%0d miso=%h expected 0 and ffffffff",
                         k, fe_cnt - fe0, miso_cap[31:0]);
            end
            ack_rx();
            n_tests++;
            if (bus.rx_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL ack[%0d]: rx_valid got %b expected 0", k, bus.rx_valid_o);
            end
        end
    endtask

    task automatic test_tx_load();
        for (int k = 0; k < 3; k++) begin
            logic [31:0]  w, exp_miso;
            int           nv;
            logic [127:0] bits;
            w  = (k == 0) ? 32'hDEADBEEF : $urandom;
            nv = (k == 0) ? 2 : int'($urandom_range(0, 4));
            @(negedge clk);
            bus.tx_data_i        = w;
            bus.tx_bytes_valid_i = 3'(nv);
            bus.tx_load_i        = 1'b1;
            @(negedge clk) bus.tx_load_i = 1'b0;
            n_tests++;
            if (bus.tx_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL tx_load[%0d]: tx_ready after load got %b expected 0", k, bus.tx_ready_o);
            end
            frame_begin();
            n_tests++;
            if (bus.tx_ready_o !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL tx_start[%0d]: tx_ready=%b busy=%b expected 1 1", k, bus.tx_ready_o, busy);
            end
            bits = {4{$urandom}};
            frame_bits(32, bits);
            frame_end();
            for (int b = 0; b < 4; b++) exp_miso[8*b +: 8] = exp_tx_byte(w, nv, b);
            n_tests++;
            if (miso_cap[31:0] !== exp_miso) begin
                n_fail++;
                $display("FAIL tx_miso[%0d]: miso got %h expected %h (nv=%0d)", k, miso_cap[31:0], exp_miso, nv);
            end
            ack_rx();
        end
    endtask

    task automatic test_partial();
        for (int k = 0; k < 3; k++) begin
            int           nb, fe0;
            logic [31:0]  exp_w;
            logic [127:0] bits;
            nb    = (k == 0) ? 2 : int'($urandom_range(1, 3));
            exp_w = '0;
            bits  = '0;
            for (int b = 0; b < nb; b++) begin
                logic [7:0] v;
                v = (k == 0) ? ((b == 0) ? 8'hA5 : 8'h5A) : 8'($urandom);
                exp_w[8*b +: 8] = v;
                bits[8*b +: 8]  = v;
            end
            fe0 = fe_cnt;
            frame_begin();
            frame_bits(8 * nb, bits);
            frame_end();
            n_tests++;
            if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== exp_w ||
                bus.rx_bytes_valid_o !== 3'(nb) || fe_cnt !== fe0) begin
                n_fail++;
                $display("FAIL partial[%0d]: valid=%b data=%h bv=%0d fe=%0d expected 1 %h %0d 0",
                         k, bus.rx_valid_o, bus.rx_data_o, bus.rx_bytes_valid_o, fe_cnt - fe0, exp_w, nb);
            end
            ack_rx();
        end
    endtask

    task automatic test_frame_err();
        logic [127:0] bits;
        int           fe0;
        bits = '0;
        bits[12:0] = 13'($urandom);
        fe0 = fe_cnt;
        frame_begin();
        frame_bits(13, bits);
        frame_end();
        n_tests++;
        if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== {24'h0, bits[7:0]} ||
            bus.rx_bytes_valid_o !== 3'd1 || fe_cnt !== fe0 + 1) begin
            n_fail++;
            $display("FAIL frame_err: valid=%b data=%h bv=%0d pulses=%0d expected 1 %h 1 1",
                     bus.rx_valid_o, bus.rx_data_o, bus.rx_bytes_valid_o, fe_cnt - fe0, {24'h0, bits[7:0]});
        end
        ack_rx();
    endtask

    task automatic test_overrun();
        logic [127:0] bits;
        bits = '0;
        bits[63:0] = {$urandom, $urandom};
        frame_begin();
        frame_bits(64, bits);
        frame_end();
        n_tests++;
        if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== bits[63:32] ||
            bus.rx_bytes_valid_o !== 3'd4 || bus.rx_overrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun: valid=%b data=%h bv=%0d ovr=%b expected 1 %h 4 1",
                     bus.rx_valid_o, bus.rx_data_o, bus.rx_bytes_valid_o, bus.rx_overrun_o, bits[63:32]);
        end
        n_tests++;
        if (miso_cap[63:0] !== 64'hFFFFFFFF_FFFFFFFF) begin
            n_fail++;
            $display("FAIL underrun_miso: miso got %h expected ffffffffffffffff", miso_cap[63:0]);
        end
        ack_rx();
    endtask

    task automatic test_reset_midframe();
        logic [127:0] bits;
        int           fe0;
        bits = {4{$urandom}};
        frame_begin();
        frame_bits(12, bits);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset_midframe");
        fe0 = fe_cnt;
        frame_bits(16, bits);
        frame_end();
        n_tests++;
        if (bus.rx_valid_o !== 1'b0 || fe_cnt !== fe0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_frame: valid=%b fe=%0d busy=%b expected 0 0 0",
                     bus.rx_valid_o, fe_cnt - fe0, busy);
        end
        bits = '0;
        bits[31:0] = $urandom;
        frame_begin();
        frame_bits(32, bits);
        frame_end();
        n_tests++;
        if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== bits[31:0] || bus.rx_overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL recovery: valid=%b data=%h ovr=%b expected 1 %h 0",
                     bus.rx_valid_o, bus.rx_data_o, bus.rx_overrun_o, bits[31:0]);
        end
        ack_rx();
    endtask

    initial begin
        bus.tx_data_i        = '0;
        bus.tx_bytes_valid_i = '0;
        bus.tx_load_i        = 1'b0;
        bus.rx_ack_i         = 1'b0;
        test_reset();
        test_full_word();
        test_tx_load();
        test_partial();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
